// File: rtl/cmd_frame_assembler_if.sv
// rtl/cmd_frame_assembler_if.sv - byte input, frame output and status bundle of the frame assembler
interface cmd_frame_assembler_if #(
    parameter int NUM_OPERANDS = 2
);
    logic                      rx_data_ready;
    logic [7:0]                rx_data;
    logic                      frame_valid;
    logic                      frame_ready;
    logic [7:0]                frame_op;
    logic [8*NUM_OPERANDS-1:0] frame_operands;
    logic [3:0]                byte_count;
    logic                      timeout_err;
    logic                      overrun_err;
    logic                      checksum_err;

    modport master (
        input  rx_data_ready,
        input  rx_data,
        input  frame_ready,
        output frame_valid,
        output frame_op,
        output frame_operands,
        output byte_count,
        output timeout_err,
        output overrun_err,
        output checksum_err
    );

    modport slave (
        output rx_data_ready,
        output rx_data,
        output frame_ready,
        input  frame_valid,
        input  frame_op,
        input  frame_operands,
        input  byte_count,
        input  timeout_err,
        input  overrun_err,
        input  checksum_err
    );
endinterface

// File: rtl/cmd_frame_assembler.sv
// rtl/cmd_frame_assembler.sv - opcode/operand frame assembler with timeout, overrun and checksum checks
// Defining FRAME_CHECKSUM_EN adds a trailing XOR checksum byte and the CHECK state.
module cmd_frame_assembler #(
    parameter int NUM_OPERANDS   = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    cmd_frame_assembler_if.master bus
);
    localparam int            OW       = 8 * NUM_OPERANDS;
    localparam bit            TMO_EN   = (TIMEOUT_CYCLES > 0);
    localparam int            TW       = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TMO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [TW-1:0] TMO_ONE  = TMO_EN ? TW'(1) : '0;
    localparam logic [3:0]    LAST_CNT = 4'(NUM_OPERANDS);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OPERANDS = 2'd1
`ifdef FRAME_CHECKSUM_EN
        ,
        ST_CHECK    = 2'd2
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      byte_count_q, byte_count_d;
    logic [7:0]      op_stage_q, op_stage_d;
    logic [OW-1:0]   opnd_stage_q, opnd_stage_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            frame_valid_q, frame_valid_d;
    logic [7:0]      frame_op_q, frame_op_d;
    logic [OW-1:0]   frame_operands_q, frame_operands_d;
    logic            timeout_err_q, timeout_err_d;
    logic            overrun_err_q, overrun_err_d;
    logic            checksum_err_d;
    logic            complete;
    logic            discard;
    logic [3:0]      slot;

`ifdef FRAME_CHECKSUM_EN
    logic            checksum_err_q;
    logic [7:0]      csum;

    always_comb begin
        csum = op_stage_q;
        for (int k = 0; k < NUM_OPERANDS; k++) begin
            csum = csum ^ opnd_stage_q[8*k +: 8];
        end
    end
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q          <= ST_IDLE;
            byte_count_q     <= 4'd0;
            op_stage_q       <= 8'd0;
            opnd_stage_q     <= '0;
            tmo_cnt_q        <= '0;
            frame_valid_q    <= 1'b0;
            frame_op_q       <= 8'd0;
            frame_operands_q <= '0;
            timeout_err_q    <= 1'b0;
            overrun_err_q    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            checksum_err_q   <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            byte_count_q     <= byte_count_d;
            op_stage_q       <= op_stage_d;
            opnd_stage_q     <= opnd_stage_d;
            tmo_cnt_q        <= tmo_cnt_d;
            frame_valid_q    <= frame_valid_d;
            frame_op_q       <= frame_op_d;
            frame_operands_q <= frame_operands_d;
            timeout_err_q    <= timeout_err_d;
            overrun_err_q    <= overrun_err_d;
`ifdef FRAME_CHECKSUM_EN
            checksum_err_q   <= checksum_err_d;
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        byte_count_d     = byte_count_q;
        op_stage_d       = op_stage_q;
        opnd_stage_d     = opnd_stage_q;
        tmo_cnt_d        = tmo_cnt_q;
        frame_valid_d    = frame_valid_q;
        frame_op_d       = frame_op_q;
        frame_operands_d = frame_operands_q;
        timeout_err_d    = 1'b0;
        overrun_err_d    = 1'b0;
        checksum_err_d   = 1'b0;
        complete         = 1'b0;
        discard          = 1'b0;
        slot             = byte_count_q - 4'd1;

        if (frame_valid_q && bus.frame_ready) begin
            frame_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_data_ready) begin
                    op_stage_d   = bus.rx_data;
                    byte_count_d = 4'd1;
                    tmo_cnt_d    = TMO_ONE;
                    state_d      = ST_OPERANDS;
                end
            end
            ST_OPERANDS: begin
                if (bus.rx_data_ready) begin
                    for (int k = 0; k < NUM_OPERANDS; k++) begin
                        if (4'(k) == slot) begin
                            opnd_stage_d[8*k +: 8] = bus.rx_data;
                        end
                    end
                    tmo_cnt_d    = TMO_ONE;
                    byte_count_d = byte_count_q + 4'd1;
                    if (byte_count_q == LAST_CNT) begin
`ifdef FRAME_CHECKSUM_EN
                        state_d  = ST_CHECK;
`else
                        complete = 1'b1;
`endif
                    end
                end
            end
`ifdef FRAME_CHECKSUM_EN
            ST_CHECK: begin
                if (bus.rx_data_ready) begin
                    if (bus.rx_data == csum) begin
                        complete = 1'b1;
                    end else begin
                        checksum_err_d = 1'b1;
                        discard        = 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (complete || discard) begin
            state_d      = ST_IDLE;
            byte_count_d = 4'd0;
            tmo_cnt_d    = '0;
        end

        // A handshake on the completion edge frees the holding register for the new frame.
        if (complete) begin
            if (!frame_valid_q || bus.frame_ready) begin
                frame_valid_d    = 1'b1;
                frame_op_d       = op_stage_d;
                frame_operands_d = opnd_stage_d;
            end else begin
                overrun_err_d = 1'b1;
            end
        end

        // The counter holds elapsed cycles including the strobe cycle; a byte in the firing cycle wins.
        if (TMO_EN && (state_q != ST_IDLE) && !bus.rx_data_ready) begin
            if (tmo_cnt_q >= TMO_LAST) begin
                timeout_err_d = 1'b1;
                state_d       = ST_IDLE;
                byte_count_d  = 4'd0;
                tmo_cnt_d     = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
        end
    end

    assign bus.frame_valid    = frame_valid_q;
    assign bus.frame_op       = frame_op_q;
    assign bus.frame_operands = frame_operands_q;
    assign bus.byte_count     = byte_count_q;
    assign bus.timeout_err    = timeout_err_q;
    assign bus.overrun_err    = overrun_err_q;
`ifdef FRAME_CHECKSUM_EN
    assign bus.checksum_err   = checksum_err_q;
`else
    assign bus.checksum_err   = 1'b0;
`endif
endmodule

// File: tb/tb_cmd_frame_assembler.sv
// tb/tb_cmd_frame_assembler.sv - self-checking bench for cmd_frame_assembler with randomized frames
module tb_cmd_frame_assembler;
    localparam int NOPS = 2;
    localparam int TMO  = 16;
    localparam int OW   = 8 * NOPS;

    logic clock;
    logic reset;
    int   total;
    int   passed;
    int   fails;

    cmd_frame_assembler_if #(.NUM_OPERANDS(NOPS)) bus ();

    cmd_frame_assembler #(
        .NUM_OPERANDS   (NOPS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input logic v, input logic [7:0] op, input logic [OW-1:0] opnds);
        chk({tag, ".valid"}, 64'(bus.frame_valid), 64'(v));
        chk({tag, ".op"}, 64'(bus.frame_op), 64'(op));
        chk({tag, ".operands"}, 64'(bus.frame_operands), 64'(opnds));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data_ready = 1'b1;
        bus.rx_data       = b;
        @(posedge clock);
        #1;
        bus.rx_data_ready = 1'b0;
    endtask

    // Frame = opcode, operands in arrival order, then (checksum build) XOR of all previous bytes.
    task automatic send_frame(input logic [7:0] op, input logic [OW-1:0] opnds, input bit bad,
                              input int gap, input bit ready_last);
        logic [7:0] bytes[$];
        logic [7:0] cs;
        bytes.push_back(op);
        for (int k = 0; k < NOPS; k++) bytes.push_back(opnds[8*k +: 8]);
        cs = 8'd0;
        foreach (bytes[i]) cs = cs ^ bytes[i];
`ifdef FRAME_CHECKSUM_EN
        bytes.push_back(bad ? (cs ^ 8'h01) : cs);
`endif
        for (int i = 0; i < bytes.size(); i++) begin
            if (i == bytes.size() - 1 && ready_last) bus.frame_ready = 1'b1;
            send_byte(bytes[i]);
            if (i < bytes.size() - 1) tick(gap);
        end
        if (ready_last) bus.frame_ready = 1'b0;
    endtask

    function automatic logic [OW-1:0] rand_opnds();
        logic [OW-1:0] r;
        for (int k = 0; k < NOPS; k++) r[8*k +: 8] = 8'($urandom);
        return r;
    endfunction

    logic [7:0]    a_op, b_op;
    logic [OW-1:0] a_opnds, b_opnds;

    initial begin
        total = 0;
        passed = 0;
        fails = 0;
        reset = 1'b1;
        bus.rx_data_ready = 1'b0;
        bus.rx_data = 8'd0;
        bus.frame_ready = 1'b0;
        tick(3);
        chk_frame("reset", 1'b0, 8'h00, '0);
        chk("reset.byte_count", 64'(bus.byte_count), 64'd0);
        chk("reset.errs", 64'({bus.timeout_err, bus.overrun_err, bus.checksum_err}), 64'd0);
        reset = 1'b0;
        tick(1);

        // ready while nothing is held has no effect
        bus.frame_ready = 1'b1;
        tick(2);
        chk("idle_ready.valid", 64'(bus.frame_valid), 64'd0);

        send_byte(8'h01);
        chk("basic.count1", 64'(bus.byte_count), 64'd1);
        send_byte(8'h12);
        chk("basic.count2", 64'(bus.byte_count), 64'd2);
        send_frame_tail_basic();
        chk_frame("basic", 1'b1, 8'h01, OW'(16'h3412));
        chk("basic.count0", 64'(bus.byte_count), 64'd0);
        tick(1);
        chk("basic.drop", 64'(bus.frame_valid), 64'd0);

        for (int f = 0; f < 6; f++) begin
            a_op = 8'($urandom);
            a_opnds = rand_opnds();
            send_frame(a_op, a_opnds, 1'b0, int'($urandom_range(0, 10)), 1'b0);
            chk_frame($sformatf("rand%0d", f), 1'b1, a_op, a_opnds);
            chk($sformatf("rand%0d.overrun", f), 64'(bus.overrun_err), 64'd0);
            tick(1);
            chk($sformatf("rand%0d.drop", f), 64'(bus.frame_valid), 64'd0);
        end

        bus.frame_ready = 1'b0;
        a_op = 8'($urandom);
        a_opnds = rand_opnds();
        b_op = ~a_op;
        b_opnds = ~a_opnds;
        send_frame(a_op, a_opnds, 1'b0, 1, 1'b0);
        chk_frame("ovr.first", 1'b1, a_op, a_opnds);
        send_frame(b_op, b_opnds, 1'b0, 0, 1'b0);
        chk("ovr.pulse", 64'(bus.overrun_err), 64'd1);
        chk_frame("ovr.held", 1'b1, a_op, a_opnds);
        tick(1);
        chk("ovr.pulse_end", 64'(bus.overrun_err), 64'd0);
        bus.frame_ready = 1'b1;
        tick(1);
        chk("ovr.drain", 64'(bus.frame_valid), 64'd0);

        send_byte(8'h05);
        send_byte(8'hAA);
        chk("tmo.count2", 64'(bus.byte_count), 64'd2);
        tick(TMO - 2);
        chk("tmo.early", 64'(bus.timeout_err), 64'd0);
        chk("tmo.early_count", 64'(bus.byte_count), 64'd2);
        tick(1);
        chk("tmo.pulse", 64'(bus.timeout_err), 64'd1);
        chk("tmo.count0", 64'(bus.byte_count), 64'd0);
        tick(1);
        chk("tmo.pulse_end", 64'(bus.timeout_err), 64'd0);
        a_op = 8'($urandom);
        a_opnds = rand_opnds();
        send_frame(a_op, a_opnds, 1'b0, 0, 1'b0);
        chk_frame("tmo.clean", 1'b1, a_op, a_opnds);
        tick(1);

        // a byte arriving in the last cycle before the timeout keeps the frame alive
        send_byte(8'h07);
        tick(TMO - 2);
        send_byte(8'h08);
        chk("late.count", 64'(bus.byte_count), 64'd2);
        chk("late.tmo", 64'(bus.timeout_err), 64'd0);
        send_byte(8'h09);
`ifdef FRAME_CHECKSUM_EN
        send_byte(8'h07 ^ 8'h08 ^ 8'h09);
`endif
        chk_frame("late.frame", 1'b1, 8'h07, OW'(16'h0908));
        tick(1);

        bus.frame_ready = 1'b0;
        a_op = 8'($urandom);
        a_opnds = rand_opnds();
        b_op = a_op + 8'd1;
        b_opnds = rand_opnds();
        send_frame(a_op, a_opnds, 1'b0, 0, 1'b0);
        tick(2);
        send_frame(b_op, b_opnds, 1'b0, 2, 1'b1);
        chk_frame("same_edge", 1'b1, b_op, b_opnds);
        chk("same_edge.overrun", 64'(bus.overrun_err), 64'd0);
        bus.frame_ready = 1'b1;
        tick(1);
        chk("same_edge.drain", 64'(bus.frame_valid), 64'd0);

`ifdef FRAME_CHECKSUM_EN
        send_frame(8'h02, OW'(16'h2010), 1'b0, 0, 1'b0);
        chk_frame("csum.good", 1'b1, 8'h02, OW'(16'h2010));
        chk("csum.good_err", 64'(bus.checksum_err), 64'd0);
        tick(1);
        send_frame(8'h02, OW'(16'h2010), 1'b1, 0, 1'b0);
        chk("csum.bad_err", 64'(bus.checksum_err), 64'd1);
        chk("csum.bad_valid", 64'(bus.frame_valid), 64'd0);
        tick(1);
        chk("csum.pulse_end", 64'(bus.checksum_err), 64'd0);
`else
        chk("csum.tied", 64'(bus.checksum_err), 64'd0);
`endif

        bus.frame_ready = 1'b0;
        a_op = 8'($urandom);
        a_opnds = rand_opnds();
        send_frame(a_op, a_opnds, 1'b0, 0, 1'b0);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("areset.pre_count", 64'(bus.byte_count), 64'd2);
        #3;
        reset = 1'b1;
        #1;
        chk_frame("areset", 1'b0, 8'h00, '0);
        chk("areset.count", 64'(bus.byte_count), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick(1);
        b_op = 8'($urandom);
        b_opnds = rand_opnds();
        send_frame(b_op, b_opnds, 1'b0, 1, 1'b0);
        chk_frame("areset.fresh", 1'b1, b_op, b_opnds);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    task automatic send_frame_tail_basic();
        send_byte(8'h34);
`ifdef FRAME_CHECKSUM_EN
        send_byte(8'h01 ^ 8'h12 ^ 8'h34);
`endif
    endtask
endmodule

// File: doc/cmd_frame_assembler.md
# cmd_frame_assembler

- Parametrised successor to the fixed three-byte opcode/A/B receiver.
- Sits between the UART receiver and the ALU/command executor.
- Collects one opcode byte followed by `NUM_OPERANDS` operand bytes into a frame, and presents the frame on a valid/ready output with a one-deep holding register.
- Adds an inter-byte timeout, overrun detection and an optional checksum byte.

## Interface
- `NUM_OPERANDS`, 2, operand bytes per frame (1..8)
- `TIMEOUT_CYCLES`, 1000, idle clock cycles after a byte before a partial frame is discarded; 0 disables the timeout
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `rx_data_ready`  in  1  one-cycle strobe: `rx_data` holds a received byte
- `rx_data`  in  8  received byte
- `frame_valid`  out  1  held frame available
- `frame_ready`  in  1  consumer accepts the held frame this cycle
- `frame_op`  out  8  opcode byte of the held frame
- `frame_operands`  out  8*NUM_OPERANDS  operand k at bits [8k+7:8k]; operand 0 is the first received
- `byte_count`  out  4  bytes accepted into the current partial frame
- `timeout_err`  out  1  one-cycle pulse: partial frame dropped by timeout
- `overrun_err`  out  1  one-cycle pulse: completed frame dropped because the holding register was full
- `checksum_err`  out  1  one-cycle pulse: checksum mismatch; constant 0 when `FRAME_CHECKSUM_EN` is undefined

## Operation
- States:
  - IDLE: waiting for the opcode.
  - OPERANDS: collecting operand bytes.
  - CHECK: waiting for the checksum byte; exists only with `FRAME_CHECKSUM_EN`.
- IDLE + strobe: store the opcode, set `byte_count`=1, go to OPERANDS.
- OPERANDS + strobe: store the byte in slot `byte_count`-1 and increment `byte_count`. When the last operand is stored:
  - with `FRAME_CHECKSUM_EN`: go to CHECK;
  - without it: complete the frame.
- CHECK + strobe: compare the byte with the XOR of the opcode and all operands.
  - Equal: complete the frame.
  - Mismatch: pulse `checksum_err` and discard the frame.
- Completion:
  - If the holding register is empty, or `frame_valid && frame_ready` in the same cycle: copy the staging registers to the outputs and set `frame_valid`.
  - Otherwise: drop the frame and pulse `overrun_err`. The held frame is unchanged.
- Every completion or discard returns to IDLE with `byte_count`=0.
- Timeout:
  - The counter resets on every accepted byte and counts while the state is not IDLE.
  - On reaching `TIMEOUT_CYCLES`: pulse `timeout_err` and return to IDLE.
  - If a strobe arrives in the same cycle the count is reached, the byte wins and no timeout occurs.
- Outputs `frame_op`/`frame_operands` change only on load; they stay stable while `frame_valid` is high.
- Reset values: `frame_valid`=0, `frame_op`=0, `frame_operands`=0, `byte_count`=0, all error pulses 0, state IDLE, timeout counter 0.
- Reset mid-frame discards the partial frame and any held frame.

## Timing
- The cycle after the strobe of the final byte (last operand, or the checksum byte):
  - the frame is on the outputs with `frame_valid`=1, or
  - the relevant error output pulses.
- Handshake completes on any rising edge with `frame_valid && frame_ready`.
  - `frame_valid` drops the next cycle unless a new frame loads on that same edge; in that case it stays high with the new data.
- `frame_ready` while `frame_valid`=0 has no effect.
- Error pulses last exactly one cycle and are registered.
- Timeout fires `TIMEOUT_CYCLES` cycles after the last accepted byte's strobe cycle.
- Byte acceptance never stalls; `rx_data_ready` has no backpressure.

## Configuration
- `FRAME_CHECKSUM_EN` defined:
  - frame length is `NUM_OPERANDS`+2 bytes;
  - CHECK state and comparator present;
  - `checksum_err` is live.
- `FRAME_CHECKSUM_EN` undefined:
  - frame length is `NUM_OPERANDS`+1 bytes;
  - no CHECK state;
  - `checksum_err` tied to 0.

## Test plan
- Default params, no checksum; bytes 0x01, 0x12, 0x34 with `frame_ready`=1 -> `frame_op`=0x01, `frame_operands`=0x3412, `frame_valid` high one cycle after the third strobe, low one cycle later.
- `frame_ready`=0; send two complete frames -> first frame held unchanged, `overrun_err` pulses once one cycle after the sixth strobe.
- `TIMEOUT_CYCLES`=16; send 0x05, 0xAA then nothing -> `timeout_err` pulses 16 cycles after the 0xAA strobe, `byte_count` returns to 0; the next 3 bytes form a clean frame.
- `FRAME_CHECKSUM_EN` defined; send 0x02, 0x10, 0x20, 0x32 -> frame delivered. Send 0x02, 0x10, 0x20, 0x33 -> `checksum_err` pulses, `frame_valid` stays 0.
- Assert `reset` asynchronously after the operand 0 strobe -> all outputs 0 immediately; after release, a fresh 3-byte frame is assembled correctly.
- `NUM_OPERANDS`=4; last byte strobed on the same edge as a handshake of the previous frame -> `frame_valid` stays high, outputs switch to the new frame, no `overrun_err`.
